obstacle_spawner: RTL and testbench

OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

---
 rtl/obstacle_spawner_pkg.sv | 41 ++++
 rtl/obstacle_slot_table.sv | 82 ++++++++
 rtl/obstacle_spawner.sv | 173 +++++++++++++++++
 tb/tb_obstacle_spawner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_spawner_pkg.sv
// Shared game package: FSM state encoding, default geometry and field widths.
package obstacle_spawner_pkg;

    localparam int unsigned SCREEN_W_DEF   = 160;
    localparam int unsigned LANE_Y0_DEF    = 20;
    localparam int unsigned LANE_PITCH_DEF = 24;
    localparam int unsigned MIN_GAP_DEF    = 8;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CD_W   = 6;
    localparam int unsigned RAND_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ERASE,
        ST_MOVE,
        ST_PAINT,
        ST_SPAWN_CHK,
        ST_SPAWN_PAINT
    } state_t;

    // One drawer command: position plus erase(1)/paint(0).
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           erase;
    } draw_cmd_t;

    // Pixel row of a lane.
    function automatic logic [Y_W-1:0] lane_y(input logic [LANE_W-1:0] lane,
                                              input int unsigned       y0,
                                              input int unsigned       pitch);
        return Y_W'(y0 + 32'(lane) * pitch);
    endfunction

endpackage

// File: rtl/obstacle_slot_table.sv
// Obstacle slot storage: valid/x/lane per slot, free-slot finder, live count.
module obstacle_slot_table
    import obstacle_spawner_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SCREEN_W  = SCREEN_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid_c,
    output logic [X_W-1:0]    rd_x_c,
    output logic [LANE_W-1:0] rd_lane_c,
    input  logic              move,
    input  logic              kill,
    input  logic              spawn,
    input  logic [LANE_W-1:0] spawn_lane,
    output logic              free_any_c,
    output logic [IDX_W-1:0]  free_idx_c,
    output logic [CNT_W-1:0]  active_cnt
);

    logic [NUM_SLOTS-1:0] valid;
    logic [X_W-1:0]       xpos [NUM_SLOTS];
    logic [LANE_W-1:0]    lane [NUM_SLOTS];

    // Read port for the slot currently being scanned; out-of-range index reads as empty.
    always_comb begin
        rd_valid_c = 1'b0;
        rd_x_c     = '0;
        rd_lane_c  = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_valid_c = valid[i];
                rd_x_c     = xpos[i];
                rd_lane_c  = lane[i];
            end
        end
    end

    // Lowest-index free slot; iterate downward so the lowest index wins.
    always_comb begin
        free_any_c = 1'b0;
        free_idx_c = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_any_c = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    // Slot updates: move/kill act on the scanned slot, spawn fills the free slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid      <= '0;
            active_cnt <= '0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                xpos[i] <= '0;
                lane[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    if (move) xpos[i]  <= xpos[i] - X_W'(1);
                    if (kill) valid[i] <= 1'b0;
                end
                if (spawn && free_any_c && (free_idx_c == IDX_W'(i))) begin
                    valid[i] <= 1'b1;
                    xpos[i]  <= X_W'(SCREEN_W - 1);
                    lane[i]  <= spawn_lane;
                end
            end
            if (spawn && free_any_c) begin
                active_cnt <= active_cnt + CNT_W'(1);
            end else if (kill && rd_valid_c) begin
                active_cnt <= active_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: per step, erase/move/repaint every live obstacle, then maybe spawn one.
module obstacle_spawner
    import obstacle_spawner_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned LANE_Y0    = LANE_Y0_DEF,
    parameter int unsigned LANE_PITCH = LANE_PITCH_DEF,
    parameter int unsigned MIN_GAP    = MIN_GAP_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              next,
    input  logic [RAND_W-1:0] rand_val,   // LFSR value; "rand" is a reserved word
    output logic              draw_req,
    output logic [X_W-1:0]    draw_x,
    output logic [Y_W-1:0]    draw_y,
    output logic              draw_erase,
    input  logic              draw_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  active_cnt,
    output logic              overrun
);

    state_t          state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [CD_W-1:0]  countdown, cd_d, cd_dec, cd_reload;
    logic             pending, pending_d, overrun_d;
    draw_cmd_t        cmd, cmd_d;
    logic             step;
    logic             move, kill, spawn;

    logic              rd_valid_c;
    logic [X_W-1:0]    rd_x_c;
    logic [LANE_W-1:0] rd_lane_c;
    logic              free_any_c;
    logic [IDX_W-1:0]  free_idx_c;

    obstacle_slot_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .SCREEN_W  (SCREEN_W)
    ) u_slots (
        .clock      (clock),
        .reset      (reset),
        .rd_idx     (idx),
        .rd_valid_c (rd_valid_c),
        .rd_x_c     (rd_x_c),
        .rd_lane_c  (rd_lane_c),
        .move       (move),
        .kill       (kill),
        .spawn      (spawn),
        .spawn_lane (rand_val[1:0]),
        .free_any_c (free_any_c),
        .free_idx_c (free_idx_c),
        .active_cnt (active_cnt)
    );

    assign step      = next & enable;
    assign cd_dec    = (countdown == '0) ? '0 : countdown - CD_W'(1);
    assign cd_reload = CD_W'(MIN_GAP) + CD_W'(rand_val[4:2]);

    assign draw_x     = cmd.x;
    assign draw_y     = cmd.y;
    assign draw_erase = cmd.erase;

    // Next-state, slot controls, drawer command and step-latching logic.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cd_d      = countdown;
        cmd_d     = cmd;
        move      = 1'b0;
        kill      = 1'b0;
        spawn     = 1'b0;
        pending_d = pending;
        overrun_d = overrun;

        // A step seen in IDLE starts a sequence; if a pending one starts instead, the new step stays queued.
        if (state == ST_IDLE) begin
            pending_d = pending & step;
        end else if (step) begin
            if (pending) overrun_d = 1'b1;
            else         pending_d = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (step || pending) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                if (idx >= IDX_W'(NUM_SLOTS)) begin
                    state_d = ST_SPAWN_CHK;
                end else if (rd_valid_c) begin
                    state_d = ST_ERASE;
                    cmd_d   = '{x: rd_x_c, y: lane_y(rd_lane_c, LANE_Y0, LANE_PITCH), erase: 1'b1};
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            ST_ERASE: begin
                if (draw_ack) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                if (rd_x_c == '0) begin
                    kill    = 1'b1;
                    idx_d   = idx + IDX_W'(1);
                    state_d = ST_SCAN;
                end else begin
                    move      = 1'b1;
                    cmd_d.x   = rd_x_c - X_W'(1);
                    cmd_d.erase = 1'b0;
                    state_d   = ST_PAINT;
                end
            end
            ST_PAINT: begin
                if (draw_ack) begin
                    idx_d   = idx + IDX_W'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_SPAWN_CHK: begin
                state_d = ST_IDLE;
                if (cd_dec != '0) begin
                    cd_d = cd_dec;
                end else begin
                    cd_d = cd_reload;
                    if (free_any_c) begin
                        spawn   = 1'b1;
                        cmd_d   = '{x: X_W'(SCREEN_W - 1),
                                    y: lane_y(rand_val[1:0], LANE_Y0, LANE_PITCH),
                                    erase: 1'b0};
                        state_d = ST_SPAWN_PAINT;
                    end
                end
            end
            ST_SPAWN_PAINT: begin
                if (draw_ack) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; draw_req/busy follow the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            countdown <= CD_W'(MIN_GAP);
            pending   <= 1'b0;
            overrun   <= 1'b0;
            cmd       <= '0;
            draw_req  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            countdown <= cd_d;
            pending   <= pending_d;
            overrun   <= overrun_d;
            cmd       <= cmd_d;
            draw_req  <= (state_d == ST_ERASE) || (state_d == ST_PAINT) ||
                         (state_d == ST_SPAWN_PAINT);
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner with a scripted pixel drawer.
module tb_obstacle_spawner;

    logic       clock = 1'b0;
    logic       reset, enable, next, draw_ack;
    logic [4:0] rand_val;
    logic       draw_req, draw_erase, busy, overrun;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [3:0] active_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    int ev_x [64];
    int ev_y [64];
    int ev_e [64];
    int ev_n;

    always #5 clock = ~clock;

    obstacle_spawner dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .next       (next),
        .rand_val   (rand_val),
        .draw_req   (draw_req),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_erase (draw_erase),
        .draw_ack   (draw_ack),
        .busy       (busy),
        .active_cnt (active_cnt),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One step pulse, then serve every draw request (ack after 'delay' cycles)
    // until the DUT has been idle for 3 cycles. 'extra' more step pulses are
    // injected on alternate cycles of the first ack waits.
    task automatic do_step(input int delay, input int extra);
        int quiet, guard, xtra;
        ev_n = 0;
        xtra = extra;
        @(negedge clock);
        next = 1'b1;
        @(negedge clock);
        next  = 1'b0;
        quiet = 0;
        guard = 0;
        while (quiet < 3 && guard < 2000) begin
            guard++;
            if (draw_req) begin
                quiet = 0;
                if (ev_n < 64) begin
                    ev_x[ev_n] = int'(draw_x);
                    ev_y[ev_n] = int'(draw_y);
                    ev_e[ev_n] = int'(draw_erase);
                end
                ev_n++;
                for (int w = 0; w < delay; w++) begin
                    if (xtra > 0 && (w % 2) == 0) begin
                        next = 1'b1;
                        xtra--;
                    end else begin
                        next = 1'b0;
                    end
                    @(negedge clock);
                end
                next     = 1'b0;
                draw_ack = 1'b1;
                @(negedge clock);
                draw_ack = 1'b0;
            end else begin
                quiet = busy ? 0 : quiet + 1;
                @(negedge clock);
            end
        end
        if (quiet < 3) check("drain_done", quiet, 3);
    endtask

    initial begin
        int w;
        reset    = 1'b1;
        enable   = 1'b1;
        next     = 1'b0;
        draw_ack = 1'b0;
        rand_val = 5'b10110;
        repeat (3) @(negedge clock);

        check("rst_draw_req", int'(draw_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_active", int'(active_cnt), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_draw_x", int'(draw_x), 0);
        check("rst_draw_y", int'(draw_y), 0);
        reset = 1'b0;
        @(negedge clock);

        // First spawn after 8 steps (lane 2, +5), then +7 reloads (lane 1) fill all slots.
        for (int k = 1; k <= 171; k++) begin
            do_step(0, 0);
            if (k == 7) check("s7_no_draw", ev_n, 0);
            if (k == 8) begin
                check("s8_ev_n", ev_n, 1);
                check("s8_x", ev_x[0], 159);
                check("s8_y", ev_y[0], 68);
                check("s8_erase", ev_e[0], 0);
                check("s8_active", int'(active_cnt), 1);
                rand_val = 5'b11101;
            end
            if (k == 20) check("s20_ev_n", ev_n, 2);
            if (k == 21) begin
                check("s21_ev_n", ev_n, 3);
                check("s21_old_erase_x", ev_x[0], 147);
                check("s21_old_paint_x", ev_x[1], 146);
                check("s21_spawn_x", ev_x[2], 159);
                check("s21_spawn_y", ev_y[2], 44);
                check("s21_active", int'(active_cnt), 2);
            end
            if (k == 156) begin
                check("s156_full_ev_n", ev_n, 8);
                check("s156_last_is_paint", ev_e[7], 0);
                check("s156_active", int'(active_cnt), 4);
            end
            if (k == 167) begin
                check("s167_erase_x", ev_x[0], 1);
                check("s167_erase_y", ev_y[0], 68);
                check("s167_erase_e", ev_e[0], 1);
                check("s167_paint_x", ev_x[1], 0);
                check("s167_paint_e", ev_e[1], 0);
                check("s167_active", int'(active_cnt), 4);
            end
            if (k == 168) begin
                check("s168_ev_n", ev_n, 7);
                check("s168_erase0_x", ev_x[0], 0);
                check("s168_erase0_e", ev_e[0], 1);
                check("s168_next_x", ev_x[1], 13);
                check("s168_next_e", ev_e[1], 1);
                check("s168_active", int'(active_cnt), 3);
            end
            if (k == 171) begin
                check("s171_ev_n", ev_n, 7);
                check("s171_spawn_x", ev_x[6], 159);
                check("s171_spawn_y", ev_y[6], 44);
                check("s171_spawn_e", ev_e[6], 0);
                check("s171_active", int'(active_cnt), 4);
                check("s171_overrun", int'(overrun), 0);
            end
        end

        // Slow drawer, two extra steps during the sequence: one queued, one dropped.
        do_step(10, 2);
        check("ovr_ev_n", ev_n, 16);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_busy", int'(busy), 0);
        check("ovr_active", int'(active_cnt), 4);

        // Reset in the middle of an erase, then a stray ack.
        @(negedge clock);
        next = 1'b1;
        @(negedge clock);
        next = 1'b0;
        w = 0;
        while (!draw_req && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("pre_rst_erase", int'({draw_req, draw_erase}), 3);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_draw_req", int'(draw_req), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_active", int'(active_cnt), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        reset    = 1'b0;
        draw_ack = 1'b1;
        @(negedge clock);
        draw_ack = 1'b0;
        check("late_ack_draw_req", int'(draw_req), 0);
        repeat (3) @(negedge clock);
        check("late_ack_busy", int'(busy), 0);

        // Countdown is back to 8: spawn on the 8th step again.
        rand_val = 5'b10110;
        for (int k = 1; k <= 8; k++) begin
            do_step(0, 0);
            if (k == 7) check("r7_no_draw", ev_n, 0);
            if (k == 8) begin
                check("r8_ev_n", ev_n, 1);
                check("r8_x", ev_x[0], 159);
                check("r8_y", ev_y[0], 68);
                check("r8_active", int'(active_cnt), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
